// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM encoding and request-kind constants for the data-memory interface
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_DATA_WIDTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } mem_state_e;

    // Request kinds as seen by both the CPU side and the responder
    typedef enum logic [1:0] {
        REQ_READ  = 2'b00,
        REQ_WRITE = 2'b01,
        REQ_BURST = 2'b10
    } req_kind_e;

    // req_burst only matters for reads; a write with req_burst set is a plain write
    function automatic req_kind_e decode_req(input logic wr, input logic burst);
        if (wr) begin
            return REQ_WRITE;
        end
        if (burst) begin
            return REQ_BURST;
        end
        return REQ_READ;
    endfunction

endpackage

// File: rtl/mem_delay_pipe.sv
// rtl/mem_delay_pipe.sv - LATENCY-deep {valid, last, data} delay line with synchronous clear
module mem_delay_pipe #(
    parameter int LATENCY    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_last,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic                  o_last,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_any_valid
);

    logic [LATENCY-1:0]    r_valid;
    logic [LATENCY-1:0]    r_last;
    logic [DATA_WIDTH-1:0] r_data [LATENCY];

    // Shift valid/last every cycle; data only moves with a valid word so the
    // output data holds its last delivered value through bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_last  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_valid & i_last;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid     = r_valid[LATENCY-1];
    assign o_last      = r_last[LATENCY-1];
    assign o_data      = r_data[LATENCY-1];
    assign o_any_valid = |r_valid;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - pipelined word memory responder with single read/write and fixed-length burst read
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int DEPTH_WORDS = 32768,
    parameter int LATENCY     = 4,
    parameter int BURST_LEN   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic                  req_burst,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_last,
    output logic                  busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = $clog2(BURST_LEN);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    mem_state_e             r_state;
    logic                   r_ready;
    logic [CNT_W-1:0]       r_cnt;
    logic [ADDR_WIDTH-1:0]  r_base;

    req_kind_e              w_kind;
    logic                   w_accept;
    logic [ADDR_WIDTH-1:0]  w_burst_addr;
    logic [ADDR_WIDTH-1:0]  w_iss_addr;
    logic                   w_iss_valid;
    logic                   w_iss_last;
    logic [DATA_WIDTH-1:0]  w_iss_data;
    logic                   w_pipe_any;

    // Byte address -> storage word index; bit 0 is dropped, depth need not be a power of two
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] word;
        word = a >> 1;
        return IDX_W'(32'(word) % DEPTH_WORDS);
    endfunction

    assign w_kind   = decode_req(req_wr, req_burst);
    assign w_accept = req_valid && r_ready && !rst;

    // Burst word address wraps modulo 2^ADDR_WIDTH and is always even
    assign w_burst_addr = (r_base + (ADDR_WIDTH'(r_cnt) << 1)) & ~ADDR_WIDTH'(1);

    // Choose what enters the delay line this cycle: a burst beat or an accepted read
    always_comb begin
        w_iss_valid = 1'b0;
        w_iss_last  = 1'b0;
        w_iss_addr  = req_addr;
        if (r_state == ST_BURST) begin
            w_iss_valid = 1'b1;
            w_iss_last  = (r_cnt == CNT_W'(BURST_LEN - 1));
            w_iss_addr  = w_burst_addr;
        end else if (w_accept && (w_kind != REQ_WRITE)) begin
            w_iss_valid = 1'b1;
            w_iss_last  = (w_kind == REQ_READ);
        end
    end

    assign w_iss_data = r_mem[word_idx(w_iss_addr)];

    // Storage write at the acceptance edge; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_accept && (w_kind == REQ_WRITE)) begin
            r_mem[word_idx(req_addr)] <= req_data;
        end
    end

    // Burst sequencer: holds off new requests while beats 1..BURST_LEN-1 issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_kind == REQ_BURST)) begin
                        r_state <= ST_BURST;
                        r_ready <= 1'b0;
                        r_cnt   <= CNT_W'(1);
                        r_base  <= req_addr & ~ADDR_WIDTH'(1);
                    end
                end
                ST_BURST: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    mem_delay_pipe #(
        .LATENCY    (LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_iss_valid),
        .i_last      (w_iss_last),
        .i_data      (w_iss_data),
        .o_valid     (resp_valid),
        .o_last      (resp_last),
        .o_data      (resp_data),
        .o_any_valid (w_pipe_any)
    );

    assign req_ready = r_ready;
    assign busy      = (r_state == ST_BURST) || w_pipe_any;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 4;
    localparam int BL  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic          req_burst = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_last;
    logic          busy;

    mem_responder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH_WORDS (32768),
        .LATENCY     (LAT),
        .BURST_LEN   (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_burst  (req_burst),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: every response must match the head of the scoreboard, including its cycle
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("no_x", 32'($isunknown({resp_valid, resp_last, req_ready, busy})), 32'd0);
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", 32'(resp_data), 32'(e.data));
                    check("resp_last", 32'(resp_last), 32'(e.last));
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Drive one request, wait for acceptance, and push the expected responses.
    // Response is expected at the edge acc+LAT, i.e. visible at the negedge of cycle acc+LAT-1.
    task automatic do_req(input logic wr, input logic burst, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] exp0, output int acc);
        int w;
        w = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_burst = burst;
        req_addr  = addr;
        req_data  = data;
        @(negedge clk);
        while (!req_ready && w < 40) begin
            w++;
            @(negedge clk);
        end
        acc = cyc + 1;
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (!wr) begin
            if (burst) begin
                for (int k = 0; k < BL; k++)
                    sb.push_back('{exp0 + DW'(k), (k == BL - 1), acc + LAT - 1 + k});
            end else begin
                sb.push_back('{exp0, 1'b1, acc + LAT - 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_burst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int cnt;
        logic [AW-1:0] a;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_last", 32'(resp_last), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Write then read next cycle
        do_req(1'b1, 1'b0, 16'h0010, 16'h1234, '0, acc);
        do_req(1'b0, 1'b0, 16'h0010, '0, 16'h1234, acc);
        idle();
        wait_cyc(8);

        // Back-to-back single reads
        do_req(1'b1, 1'b0, 16'h0000, 16'h000A, '0, acc);
        do_req(1'b1, 1'b0, 16'h0002, 16'h000B, '0, acc);
        do_req(1'b1, 1'b0, 16'h0004, 16'h000C, '0, acc);
        do_req(1'b0, 1'b0, 16'h0000, '0, 16'h000A, acc);
        do_req(1'b0, 1'b0, 16'h0002, '0, 16'h000B, acc);
        do_req(1'b0, 1'b0, 16'h0004, '0, 16'h000C, acc);
        idle();
        wait_cyc(8);

        // Burst at 0x0020 with words 0..7
        for (int k = 0; k < BL; k++) begin
            a = 16'h0020 + AW'(2 * k);
            do_req(1'b1, 1'b0, a, DW'(k), '0, acc);
        end
        do_req(1'b0, 1'b1, 16'h0020, '0, 16'h0000, acc);
        idle();
        cnt = 0;
        @(negedge clk);
        while (!req_ready && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("burst_ready_low", 32'(cnt), 32'd7);
        while (cyc < acc + LAT + BL - 2) @(negedge clk);
        check("busy_at_last_resp", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_last_resp", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Burst wrapping through the top of the address space
        for (int k = 0; k < BL; k++) begin
            a = 16'hFFFC + AW'(2 * k);
            do_req(1'b1, 1'b0, a, 16'h0F00 + DW'(k), '0, acc);
        end
        do_req(1'b0, 1'b1, 16'hFFFC, '0, 16'h0F00, acc);
        idle();
        wait_cyc(14);

        // Read accepted one cycle before a write to the same word
        do_req(1'b1, 1'b0, 16'h0040, 16'h1111, '0, acc);
        do_req(1'b1, 1'b0, 16'h0060, 16'h6060, '0, acc);
        do_req(1'b0, 1'b0, 16'h0040, '0, 16'h1111, acc);
        do_req(1'b1, 1'b0, 16'h0040, 16'h2222, '0, acc);
        do_req(1'b0, 1'b0, 16'h0040, '0, 16'h2222, acc);
        idle();
        wait_cyc(8);

        // Reset in the third cycle of a burst, with a write held during reset
        do_req(1'b0, 1'b1, 16'h0020, '0, 16'h0000, acc);
        idle();
        wait_cyc(1);
        rst       = 1'b1;
        sb.delete();
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0060;
        req_data  = 16'hDEAD;
        wait_cyc(2);
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        wait_cyc(12);
        do_req(1'b0, 1'b0, 16'h0060, '0, 16'h6060, acc);
        do_req(1'b0, 1'b0, 16'h0024, '0, 16'h0002, acc);
        idle();
        wait_cyc(10);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's data-memory request interface; this is the other end of that interface.
- Multi-cycle, pipelined word memory with a fixed read latency.
- Supports single-word read and write, plus a fixed-length burst read for future cache-line fills.
- Replaces the single-cycle data memory once the CPU moves to a multi-cycle memory system.

Parameters:
- ADDR_WIDTH, 16, byte-address width; addr[0] is ignored (word aligned).
- DATA_WIDTH, 16, word width.
- DEPTH_WORDS, 32768, storage words; index = addr[ADDR_WIDTH-1:1] modulo DEPTH_WORDS.
- LATENCY, 4, cycles from read acceptance to resp_valid; must be >= 1.
- BURST_LEN, 8, words per burst read; must be >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_wr  in  1  1 = single-word write, 0 = read.
- req_burst  in  1  with req_wr=0, request a BURST_LEN-word read; ignored when req_wr=1.
- req_addr  in  ADDR_WIDTH  byte address.
- req_data  in  DATA_WIDTH  write data.
- resp_valid  out  1  read data valid this cycle. There is no response backpressure; the requester must always accept.
- resp_data  out  DATA_WIDTH  read data.
- resp_last  out  1  final word of a burst, or the only word of a single read.
- busy  out  1  burst issuing or any read in flight.

Behaviour:
- Interface: clock is clk; reset is rst, synchronous and active-high.
- Reset values: req_ready=1, resp_valid=0, resp_last=0, resp_data=0, busy=0, FSM=IDLE, all pipeline valids cleared. Storage contents are not reset.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. At most one request is accepted per cycle.
- Write:
  - Storage is updated at the acceptance edge.
  - No response is produced.
  - Any read accepted on a later cycle returns the new data.
- Single read:
  - Data is sampled from storage at the acceptance edge.
  - The sampled value travels down a LATENCY-stage valid/data/last delay line.
  - resp_valid=1 and resp_last=1 exactly LATENCY cycles after acceptance, for one cycle.
  - Back-to-back reads give one response per cycle, in order.
- Ordering: a read accepted before a write to the same address returns the old data. Data is always sampled at acceptance, never at response time.
- FSM, IDLE:
  - req_ready=1.
  - An accepted burst read issues word 0 at base addr, sets cnt=1, goes to BURST.
  - All other accepted requests stay in IDLE.
- FSM, BURST:
  - req_ready=0.
  - Each cycle issues an internal read at base + 2*cnt and increments cnt.
  - When the issued word is cnt == BURST_LEN-1, that word is tagged last and the FSM returns to IDLE.
  - Burst responses therefore appear on BURST_LEN consecutive cycles starting LATENCY cycles after acceptance. Only the final word has resp_last=1.
- Burst address arithmetic:
  - Computed modulo 2^ADDR_WIDTH; 0xFFFE wraps to 0x0000.
  - There is no alignment requirement on the base.
  - The internal address is always even.
- After the last burst word is issued, req_ready=1 again on the next cycle, so a new request can be accepted while burst responses are still draining.
- busy = (FSM==BURST) OR any delay-line stage valid.
- resp_data holds its previous value when resp_valid=0. Checkers must not inspect it.
- Reset mid-operation:
  - The FSM aborts to IDLE and all in-flight responses are discarded; no resp_valid appears after the reset edge.
  - Writes accepted before the reset edge persist.
- A request with req_valid=1 during rst=1 is not accepted.
- The responder never produces X on resp_valid, resp_last, req_ready or busy after reset.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - FSM state encoding (IDLE=1'b0, BURST=1'b1).
  - The request-kind constants shared with the CPU side.
- One sub-module, mem_delay_pipe: parameterized LATENCY-deep shift register of {valid, last, data} with synchronous clear on rst. It is also reused later for the instruction-side responder.

Test Plan:
- Write 0x1234 to 0x0010, then read 0x0010 on the next cycle -> resp_valid=1, resp_data=0x1234, resp_last=1 exactly 4 cycles after read acceptance.
- Reads of 0x0000, 0x0002, 0x0004 on consecutive cycles (preloaded 0xA, 0xB, 0xC) -> responses on three consecutive cycles, in order, each with resp_last=1.
- Burst read at base 0x0020 (words preloaded 0..7) -> req_ready low for 7 cycles after acceptance; 8 consecutive responses 0..7; resp_last only on value 7; busy drops the cycle after the last response.
- Burst read at base 0xFFFC -> addresses 0xFFFC, 0xFFFE, 0x0000, ..., 0x000A; data matches the preload; no X.
- Read 0x0040 (old value 0x1111) accepted one cycle before a write of 0x2222 to 0x0040 -> read returns 0x1111; a following read returns 0x2222.
- Assert rst during cycle 3 of a burst -> FSM returns to IDLE, req_ready=1, busy=0, no resp_valid afterwards; a new single read completes normally.
